// File: rtl/dispatch_queue_pkg.sv
// Shared types for the decode-to-rename dispatch queue.
package dispatch_queue_pkg;

    localparam int ARCH_IDX   = 5;
    localparam int PHYS_TAG   = 6;
    localparam int W_DEF      = 4;
    localparam int QDEPTH_DEF = 16;
    localparam int NBANK_DEF  = 4;

    typedef enum logic [1:0] {
        RS_ALU    = 2'd0,
        RS_MULT   = 2'd1,
        RS_BRANCH = 2'd2,
        RS_MEM    = 2'd3
    } rs_bank_idx_e;

    typedef struct packed {
        logic [ARCH_IDX-1:0] rs1;
        logic [ARCH_IDX-1:0] rs2;
        logic [ARCH_IDX-1:0] rd;
        logic                uses_rd;
        logic                is_store;
        logic                is_branch;
        logic                halt;
        logic                opb_is_rs2;
        rs_bank_idx_e        category;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic                bp_taken;
        logic [31:0]         bp_target;
    } disp_inst_t;

endpackage

// File: rtl/rename_forward.sv
// Intra-group rename: compacts free-list tags onto writing lanes and
// forwards the latest earlier in-group producer to each source.
module rename_forward
    import dispatch_queue_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0]                        lane_v,
    input  logic [W-1:0]                        urd,
    input  logic [W-1:0]                        opb_rs2,
    input  logic [W-1:0]                        halt,
    input  logic [W-1:0][ARCH_IDX-1:0]          rs1,
    input  logic [W-1:0][ARCH_IDX-1:0]          rs2,
    input  logic [W-1:0][ARCH_IDX-1:0]          rd,
    input  logic [W-1:0][2:0][PHYS_TAG-1:0]     mt_tag,
    input  logic [W-1:0][1:0]                   mt_ready,
    input  logic [W-1:0][PHYS_TAG-1:0]          fl_tags,
    output logic [W-1:0][1:0][PHYS_TAG-1:0]     src_tag,
    output logic [W-1:0][1:0]                   src_ready,
    output logic [W-1:0][PHYS_TAG-1:0]          pd,
    output logic [W-1:0][PHYS_TAG-1:0]          told,
    output logic [W-1:0]                        wr_valid,
    output logic [$clog2(W+1)-1:0]              alloc_count
);
    localparam int IW   = $clog2(W);
    localparam int CNTW = $clog2(W+1);

    logic [IW-1:0] kidx;

    always_comb begin
        kidx        = '0;
        alloc_count = '0;
        src_tag     = '0;
        src_ready   = '0;
        pd          = '0;
        told        = '0;
        wr_valid    = '0;
        for (int i = 0; i < W; i++) begin
            if (lane_v[i]) begin
                src_tag[i][0] = mt_tag[i][0];
                src_tag[i][1] = mt_tag[i][1];
                src_ready[i]  = mt_ready[i];
                told[i]       = mt_tag[i][2];
                // ascending scan so the latest earlier writer wins
                for (int j = 0; j < i; j++) begin
                    if (lane_v[j] && urd[j]) begin
                        if (rd[j] == rs1[i]) begin
                            src_tag[i][0]   = pd[j];
                            src_ready[i][0] = 1'b0;
                        end
                        if (rd[j] == rs2[i]) begin
                            src_tag[i][1]   = pd[j];
                            src_ready[i][1] = 1'b0;
                        end
                        if (rd[j] == rd[i])
                            told[i] = pd[j];
                    end
                end
                if (!opb_rs2[i] || halt[i])
                    src_ready[i][1] = 1'b1;
                if (halt[i])
                    src_ready[i][0] = 1'b1;
                if (urd[i]) begin
                    pd[i]       = fl_tags[kidx];
                    wr_valid[i] = 1'b1;
                    kidx        = kidx + IW'(1);
                    alloc_count = alloc_count + CNTW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order circular holding queue between decode and rename; each cycle
// dispatches the longest head prefix that fits all resource credits.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int QDEPTH = QDEPTH_DEF,
    parameter int NBANK  = NBANK_DEF,
    parameter int MAX_BR = 1,
    parameter int CW     = 6
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [$clog2(W+1)-1:0]              enq_count,
    input  disp_inst_t [W-1:0]                  enq_inst,
    output logic                                enq_ready,
    input  logic                                flush,
    input  logic [CW-1:0]                       rob_credits,
    input  logic [CW-1:0]                       fl_credits,
    input  logic [CW-1:0]                       sq_credits,
    input  logic [NBANK-1:0][CW-1:0]            rs_credits,
    output logic [W-1:0][2:0][ARCH_IDX-1:0]     mt_rd_addr,
    input  logic [W-1:0][2:0][PHYS_TAG-1:0]     mt_rd_tag,
    input  logic [W-1:0][1:0]                   mt_rd_ready,
    input  logic [W-1:0][PHYS_TAG-1:0]          fl_tags,
    output logic [$clog2(W+1)-1:0]              disp_count,
    output disp_inst_t [W-1:0]                  disp_inst,
    output logic [W-1:0][$clog2(NBANK)-1:0]     disp_bank,
    output logic [W-1:0][1:0][PHYS_TAG-1:0]     disp_src_tag,
    output logic [W-1:0][1:0]                   disp_src_ready,
    output logic [W-1:0][PHYS_TAG-1:0]          disp_pd,
    output logic [W-1:0][PHYS_TAG-1:0]          disp_told,
    output logic [$clog2(W+1)-1:0]              fl_alloc_count,
    output logic [W-1:0]                        mt_wr_valid,
    output logic [W-1:0][ARCH_IDX-1:0]          mt_wr_addr,
    output logic [W-1:0][PHYS_TAG-1:0]          mt_wr_tag,
    output logic [$clog2(QDEPTH+1)-1:0]         occupancy,
    output logic                                halted
);
    localparam int CNTW = $clog2(W+1);
    localparam int PW   = $clog2(QDEPTH);
    localparam int OW   = $clog2(QDEPTH+1);
    localparam int BW   = $clog2(NBANK);

    disp_inst_t queue [QDEPTH];
    logic [PW-1:0] head, tail;

    disp_inst_t [W-1:0]           lane_inst;
    logic [W-1:0]                 lane_v, lane_urd, lane_opb, lane_halt;
    logic [W-1:0][ARCH_IDX-1:0]   lane_rs1, lane_rs2, lane_rd;
    logic [W-1:0][BW-1:0]         lane_bank;
    logic [CNTW-1:0]              enq_n, disp_n;
    logic [OW-1:0]                occ_next;
    logic [CW-1:0]                n_rob, n_fl, n_sq, n_br;
    logic [CW-1:0]                n_bank [NBANK];
    logic                         go, ok;

    always_comb begin
        for (int i = 0; i < W; i++) begin
            lane_inst[i]     = queue[head + PW'(i)];
            lane_rs1[i]      = lane_inst[i].rs1;
            lane_rs2[i]      = lane_inst[i].rs2;
            lane_rd[i]       = lane_inst[i].rd;
            lane_urd[i]      = lane_inst[i].uses_rd && (lane_inst[i].rd != '0);
            lane_opb[i]      = lane_inst[i].opb_is_rs2;
            lane_halt[i]     = lane_inst[i].halt;
            lane_bank[i]     = BW'(lane_inst[i].category);
            mt_rd_addr[i][0] = lane_inst[i].rs1;
            mt_rd_addr[i][1] = lane_inst[i].rs2;
            mt_rd_addr[i][2] = lane_inst[i].rd;
        end
    end

    // Prefix selection: the first lane failing any check, or a halt, ends the group.
    always_comb begin
        go     = !halted && !flush;
        ok     = 1'b0;
        n_rob  = '0;
        n_fl   = '0;
        n_sq   = '0;
        n_br   = '0;
        disp_n = '0;
        lane_v = '0;
        for (int b = 0; b < NBANK; b++)
            n_bank[b] = '0;
        for (int i = 0; i < W; i++) begin
            ok = go && (OW'(i) < occupancy) && (n_rob < rob_credits)
                && (!lane_urd[i] || (n_fl < fl_credits))
                && (!lane_inst[i].is_store || (n_sq < sq_credits))
                && (n_bank[lane_bank[i]] < rs_credits[lane_bank[i]])
                && (!lane_inst[i].is_branch || (n_br < CW'(MAX_BR)));
            if (ok) begin
                lane_v[i] = 1'b1;
                disp_n    = disp_n + CNTW'(1);
                n_rob     = n_rob + CW'(1);
                if (lane_urd[i])
                    n_fl = n_fl + CW'(1);
                if (lane_inst[i].is_store)
                    n_sq = n_sq + CW'(1);
                if (lane_inst[i].is_branch)
                    n_br = n_br + CW'(1);
                n_bank[lane_bank[i]] = n_bank[lane_bank[i]] + CW'(1);
                if (lane_inst[i].halt)
                    go = 1'b0;
            end else begin
                go = 1'b0;
            end
        end
    end

    rename_forward #(.W(W)) u_rename_forward (
        .lane_v      (lane_v),
        .urd         (lane_urd),
        .opb_rs2     (lane_opb),
        .halt        (lane_halt),
        .rs1         (lane_rs1),
        .rs2         (lane_rs2),
        .rd          (lane_rd),
        .mt_tag      (mt_rd_tag),
        .mt_ready    (mt_rd_ready),
        .fl_tags     (fl_tags),
        .src_tag     (disp_src_tag),
        .src_ready   (disp_src_ready),
        .pd          (disp_pd),
        .told        (disp_told),
        .wr_valid    (mt_wr_valid),
        .alloc_count (fl_alloc_count)
    );

    always_comb begin
        disp_count = disp_n;
        for (int i = 0; i < W; i++) begin
            disp_inst[i]  = lane_v[i] ? lane_inst[i] : '0;
            disp_bank[i]  = lane_v[i] ? lane_bank[i] : '0;
            mt_wr_addr[i] = mt_wr_valid[i] ? lane_rd[i] : '0;
            mt_wr_tag[i]  = disp_pd[i];
        end
    end

    assign enq_n    = enq_ready ? enq_count : '0;
    assign occ_next = occupancy + OW'(enq_n) - OW'(disp_n);

    always_ff @(posedge clock) begin
        if (reset && !flush) begin
            for (int i = 0; i < W; i++)
                if (CNTW'(i) < enq_n)
                    queue[tail + PW'(i)] <= enq_inst[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            halted    <= 1'b0;
            enq_ready <= 1'b1;
        end else begin
            head      <= head + PW'(disp_n);
            tail      <= tail + PW'(enq_n);
            occupancy <= occ_next;
            enq_ready <= (OW'(QDEPTH) - occ_next) >= OW'(W);
            if (|(lane_v & lane_halt))
                halted <= 1'b1;
        end
    end

    assert property (@(posedge clock) disable iff (!reset)
        enq_ready || (enq_count == '0));

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int W      = 4;
    localparam int QDEPTH = 16;
    localparam int NBANK  = 4;
    localparam int MAX_BR = 1;
    localparam int CW     = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [2:0] enq_count = '0;
    disp_inst_t [W-1:0] enq_inst = '0;
    logic enq_ready;
    logic flush = 1'b0;
    logic [CW-1:0] rob_credits, fl_credits, sq_credits;
    logic [NBANK-1:0][CW-1:0] rs_credits;
    logic [W-1:0][2:0][ARCH_IDX-1:0] mt_rd_addr;
    logic [W-1:0][2:0][PHYS_TAG-1:0] mt_rd_tag;
    logic [W-1:0][1:0] mt_rd_ready;
    logic [W-1:0][PHYS_TAG-1:0] fl_tags;
    logic [2:0] disp_count;
    disp_inst_t [W-1:0] disp_inst;
    logic [W-1:0][1:0] disp_bank;
    logic [W-1:0][1:0][PHYS_TAG-1:0] disp_src_tag;
    logic [W-1:0][1:0] disp_src_ready;
    logic [W-1:0][PHYS_TAG-1:0] disp_pd, disp_told;
    logic [2:0] fl_alloc_count;
    logic [W-1:0] mt_wr_valid;
    logic [W-1:0][ARCH_IDX-1:0] mt_wr_addr;
    logic [W-1:0][PHYS_TAG-1:0] mt_wr_tag;
    logic [4:0] occupancy;
    logic halted;

    int n_checks = 0;
    int n_fail = 0;

    dispatch_queue #(.W(W), .QDEPTH(QDEPTH), .NBANK(NBANK), .MAX_BR(MAX_BR), .CW(CW)) dut (
        .clock(clock), .reset(reset), .enq_count(enq_count), .enq_inst(enq_inst),
        .enq_ready(enq_ready), .flush(flush), .rob_credits(rob_credits),
        .fl_credits(fl_credits), .sq_credits(sq_credits), .rs_credits(rs_credits),
        .mt_rd_addr(mt_rd_addr), .mt_rd_tag(mt_rd_tag), .mt_rd_ready(mt_rd_ready),
        .fl_tags(fl_tags), .disp_count(disp_count), .disp_inst(disp_inst),
        .disp_bank(disp_bank), .disp_src_tag(disp_src_tag),
        .disp_src_ready(disp_src_ready), .disp_pd(disp_pd), .disp_told(disp_told),
        .fl_alloc_count(fl_alloc_count), .mt_wr_valid(mt_wr_valid),
        .mt_wr_addr(mt_wr_addr), .mt_wr_tag(mt_wr_tag), .occupancy(occupancy),
        .halted(halted)
    );

    always #5 clock = ~clock;

    // map table model: arch register r is mapped to physical tag 32+r
    always_comb begin
        for (int i = 0; i < W; i++)
            for (int k = 0; k < 3; k++)
                mt_rd_tag[i][k] = {1'b1, mt_rd_addr[i][k]};
    end

    function automatic disp_inst_t mk(input int rs1, input int rs2, input int rd,
                                      input logic urd, input logic st, input logic br,
                                      input logic hlt, input logic opb,
                                      input rs_bank_idx_e cat, input int pc);
        disp_inst_t x;
        x = '0;
        x.rs1 = ARCH_IDX'(rs1);
        x.rs2 = ARCH_IDX'(rs2);
        x.rd = ARCH_IDX'(rd);
        x.uses_rd = urd;
        x.is_store = st;
        x.is_branch = br;
        x.halt = hlt;
        x.opb_is_rs2 = opb;
        x.category = cat;
        x.pc = 32'(pc);
        return x;
    endfunction

    task automatic set_credits();
        rob_credits = 6'd8;
        fl_credits = 6'd8;
        sq_credits = 6'd8;
        for (int b = 0; b < NBANK; b++)
            rs_credits[b] = 6'd8;
    endtask

    task automatic enq(input int n, input disp_inst_t l0, input disp_inst_t l1,
                       input disp_inst_t l2, input disp_inst_t l3);
        @(negedge clock);
        enq_count = 3'(n);
        enq_inst = {l3, l2, l1, l0};
        @(negedge clock);
        enq_count = '0;
        #1;
    endtask

    task automatic test_reset();
        set_credits();
        mt_rd_ready = '1;
        for (int i = 0; i < W; i++)
            fl_tags[i] = PHYS_TAG'(8 + i);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready got %b want 1", enq_ready); end
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_checks++; if (disp_count !== 3'd0) begin n_fail++; $display("FAIL reset_disp got %0d want 0", disp_count); end
        n_checks++; if (fl_alloc_count !== 3'd0) begin n_fail++; $display("FAIL reset_alloc got %0d want 0", fl_alloc_count); end
        n_checks++; if (mt_wr_valid !== 4'b0) begin n_fail++; $display("FAIL reset_mtwr got %b want 0000", mt_wr_valid); end
        reset = 1'b1;
    endtask

    task automatic test_independent();
        enq(4, mk(20, 21, 10, 1, 0, 0, 0, 1, RS_ALU, 0), mk(22, 23, 11, 1, 0, 0, 0, 1, RS_ALU, 1),
               mk(24, 25, 12, 1, 0, 0, 0, 1, RS_ALU, 2), mk(26, 27, 13, 1, 0, 0, 0, 1, RS_ALU, 3));
        n_checks++; if (disp_count !== 3'd4) begin n_fail++; $display("FAIL indep_count got %0d want 4", disp_count); end
        n_checks++; if (fl_alloc_count !== 3'd4) begin n_fail++; $display("FAIL indep_alloc got %0d want 4", fl_alloc_count); end
        for (int i = 0; i < W; i++) begin
            n_checks++; if (disp_pd[i] !== PHYS_TAG'(8 + i)) begin n_fail++; $display("FAIL indep_pd%0d got %0d want %0d", i, disp_pd[i], 8 + i); end
        end
        n_checks++; if (disp_src_tag[0][0] !== 6'd52) begin n_fail++; $display("FAIL indep_src got %0d want 52", disp_src_tag[0][0]); end
        n_checks++; if (mt_wr_valid !== 4'b1111) begin n_fail++; $display("FAIL indep_mtwr got %b want 1111", mt_wr_valid); end
        n_checks++; if (mt_wr_addr[3] !== 5'd13) begin n_fail++; $display("FAIL indep_mtaddr got %0d want 13", mt_wr_addr[3]); end
        n_checks++; if (mt_wr_tag[0] !== 6'd8) begin n_fail++; $display("FAIL indep_mttag got %0d want 8", mt_wr_tag[0]); end
        @(negedge clock); #1;
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL indep_drain got %0d want 0", occupancy); end
    endtask

    task automatic test_forward();
        enq(4, mk(5, 6, 1, 1, 0, 0, 0, 1, RS_ALU, 0), mk(1, 7, 2, 1, 0, 0, 0, 1, RS_ALU, 1),
               mk(2, 0, 1, 1, 0, 0, 0, 0, RS_ALU, 2), mk(1, 1, 1, 1, 0, 0, 0, 1, RS_ALU, 3));
        n_checks++; if (disp_src_tag[1][0] !== 6'd8) begin n_fail++; $display("FAIL fwd_l1_src got %0d want 8", disp_src_tag[1][0]); end
        n_checks++; if (disp_src_ready[1] !== 2'b10) begin n_fail++; $display("FAIL fwd_l1_rdy got %b want 10", disp_src_ready[1]); end
        n_checks++; if (disp_src_tag[2][0] !== 6'd9) begin n_fail++; $display("FAIL fwd_l2_src got %0d want 9", disp_src_tag[2][0]); end
        n_checks++; if (disp_src_ready[2] !== 2'b10) begin n_fail++; $display("FAIL fwd_l2_rdy got %b want 10", disp_src_ready[2]); end
        n_checks++; if (disp_told[0] !== 6'd33) begin n_fail++; $display("FAIL fwd_l0_told got %0d want 33", disp_told[0]); end
        n_checks++; if (disp_told[2] !== 6'd8) begin n_fail++; $display("FAIL fwd_l2_told got %0d want 8", disp_told[2]); end
        n_checks++; if (disp_src_tag[3][1] !== 6'd10) begin n_fail++; $display("FAIL fwd_l3_src2 got %0d want 10", disp_src_tag[3][1]); end
        n_checks++; if (disp_told[3] !== 6'd10) begin n_fail++; $display("FAIL fwd_l3_told got %0d want 10", disp_told[3]); end
        n_checks++; if (disp_pd[3] !== 6'd11) begin n_fail++; $display("FAIL fwd_l3_pd got %0d want 11", disp_pd[3]); end
        @(negedge clock);
    endtask

    task automatic test_x0();
        mt_rd_ready = '0;
        enq(2, mk(1, 2, 0, 1, 0, 0, 0, 1, RS_ALU, 0), mk(0, 3, 7, 1, 0, 0, 0, 0, RS_ALU, 1),
               '0, '0);
        n_checks++; if (disp_count !== 3'd2) begin n_fail++; $display("FAIL x0_count got %0d want 2", disp_count); end
        n_checks++; if (fl_alloc_count !== 3'd1) begin n_fail++; $display("FAIL x0_alloc got %0d want 1", fl_alloc_count); end
        n_checks++; if (disp_pd[1] !== 6'd8) begin n_fail++; $display("FAIL x0_pd got %0d want 8", disp_pd[1]); end
        n_checks++; if (mt_wr_valid !== 4'b0010) begin n_fail++; $display("FAIL x0_mtwr got %b want 0010", mt_wr_valid); end
        n_checks++; if (disp_src_tag[1][0] !== 6'd32) begin n_fail++; $display("FAIL x0_src got %0d want 32", disp_src_tag[1][0]); end
        n_checks++; if (disp_src_ready[1] !== 2'b10) begin n_fail++; $display("FAIL x0_rdy got %b want 10", disp_src_ready[1]); end
        @(negedge clock);
        mt_rd_ready = '1;
    endtask

    task automatic test_mem_credit();
        rs_credits[RS_MEM] = 6'd1;
        enq(3, mk(1, 0, 3, 1, 0, 0, 0, 0, RS_MEM, 0), mk(1, 2, 0, 0, 1, 0, 0, 1, RS_MEM, 1),
               mk(4, 5, 6, 1, 0, 0, 0, 1, RS_ALU, 2), '0);
        n_checks++; if (disp_count !== 3'd1) begin n_fail++; $display("FAIL mem_c1_count got %0d want 1", disp_count); end
        n_checks++; if (disp_bank[0] !== 2'd3) begin n_fail++; $display("FAIL mem_bank got %0d want 3", disp_bank[0]); end
        @(negedge clock); #1;
        n_checks++; if (occupancy !== 5'd2) begin n_fail++; $display("FAIL mem_occ got %0d want 2", occupancy); end
        n_checks++; if (disp_count !== 3'd2) begin n_fail++; $display("FAIL mem_c2_count got %0d want 2", disp_count); end
        n_checks++; if (disp_inst[0].is_store !== 1'b1) begin n_fail++; $display("FAIL mem_st_head got %b want 1", disp_inst[0].is_store); end
        n_checks++; if (disp_pd[1] !== 6'd8) begin n_fail++; $display("FAIL mem_add_pd got %0d want 8", disp_pd[1]); end
        @(negedge clock); #1;
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL mem_drain got %0d want 0", occupancy); end
        rs_credits[RS_MEM] = 6'd8;
    endtask

    task automatic test_branch_limit();
        enq(3, mk(1, 2, 0, 0, 0, 1, 0, 1, RS_BRANCH, 0), mk(3, 4, 0, 0, 0, 1, 0, 1, RS_BRANCH, 1),
               mk(4, 5, 6, 1, 0, 0, 0, 1, RS_ALU, 2), '0);
        n_checks++; if (disp_count !== 3'd1) begin n_fail++; $display("FAIL br_c1 got %0d want 1", disp_count); end
        @(negedge clock); #1;
        n_checks++; if (disp_count !== 3'd2) begin n_fail++; $display("FAIL br_c2 got %0d want 2", disp_count); end
        n_checks++; if (disp_inst[0].pc !== 32'd1) begin n_fail++; $display("FAIL br_c2_pc got %0d want 1", disp_inst[0].pc); end
        @(negedge clock);
    endtask

    task automatic test_full_wrap();
        int seq;
        int n;
        int t_rob[6]  = '{3, 8, 8, 8, 8, 8};
        int t_enq[6]  = '{0, 4, 4, 0, 0, 0};
        int t_disp[6] = '{3, 4, 4, 4, 4, 2};
        int t_pc[6]   = '{100, 103, 107, 111, 115, 119};
        int t_occ[6]  = '{13, 10, 10, 10, 6, 2};
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        rob_credits = '0;
        seq = 0;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) begin
                #1;
                n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL full_occ12_ready got %b want 1", enq_ready); end
            end
            n = (b < 3) ? 4 : 1;
            enq_count = 3'(n);
            for (int l = 0; l < W; l++)
                enq_inst[l] = mk(1, 2, 3, 0, 0, 0, 0, 1, RS_ALU, 100 + seq + l);
            seq += n;
            @(negedge clock);
        end
        enq_count = '0;
        for (int s = 0; s < 6; s++) begin
            rob_credits = 6'(t_rob[s]);
            enq_count = 3'(t_enq[s]);
            for (int l = 0; l < W; l++)
                enq_inst[l] = mk(1, 2, 3, 0, 0, 0, 0, 1, RS_ALU, 100 + seq + l);
            seq += t_enq[s];
            #1;
            n_checks++; if (occupancy !== 5'(t_occ[s])) begin n_fail++; $display("FAIL wrap_occ%0d got %0d want %0d", s, occupancy, t_occ[s]); end
            n_checks++; if (disp_count !== 3'(t_disp[s])) begin n_fail++; $display("FAIL wrap_disp%0d got %0d want %0d", s, disp_count, t_disp[s]); end
            n_checks++; if (disp_inst[0].pc !== 32'(t_pc[s])) begin n_fail++; $display("FAIL wrap_pc%0d got %0d want %0d", s, disp_inst[0].pc, t_pc[s]); end
            if (s == 0) begin
                n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", enq_ready); end
            end
            if (s == 4) begin
                n_checks++; if (disp_inst[3].pc !== 32'd118) begin n_fail++; $display("FAIL wrap_lane3_pc got %0d want 118", disp_inst[3].pc); end
            end
            @(negedge clock);
        end
        enq_count = '0;
        #1;
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL wrap_drain got %0d want 0", occupancy); end
        n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready got %b want 1", enq_ready); end
    endtask

    task automatic test_halt_flush();
        mt_rd_ready = '0;
        enq(4, mk(1, 2, 10, 1, 0, 0, 0, 1, RS_ALU, 200), mk(3, 4, 0, 0, 0, 0, 1, 1, RS_ALU, 201),
               mk(5, 6, 11, 1, 0, 0, 0, 1, RS_ALU, 202), mk(7, 8, 12, 1, 0, 0, 0, 1, RS_ALU, 203));
        n_checks++; if (disp_count !== 3'd2) begin n_fail++; $display("FAIL halt_count got %0d want 2", disp_count); end
        n_checks++; if (fl_alloc_count !== 3'd1) begin n_fail++; $display("FAIL halt_alloc got %0d want 1", fl_alloc_count); end
        n_checks++; if (disp_src_ready[1] !== 2'b11) begin n_fail++; $display("FAIL halt_rdy got %b want 11", disp_src_ready[1]); end
        n_checks++; if (disp_src_ready[0] !== 2'b00) begin n_fail++; $display("FAIL halt_l0_rdy got %b want 00", disp_src_ready[0]); end
        n_checks++; if (mt_wr_valid !== 4'b0001) begin n_fail++; $display("FAIL halt_mtwr got %b want 0001", mt_wr_valid); end
        @(negedge clock); #1;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky got %b want 1", halted); end
        n_checks++; if (occupancy !== 5'd2) begin n_fail++; $display("FAIL halt_occ got %0d want 2", occupancy); end
        n_checks++; if (disp_count !== 3'd0) begin n_fail++; $display("FAIL halt_block got %0d want 0", disp_count); end
        @(negedge clock);
        flush = 1'b1;
        enq_count = 3'd2;
        @(negedge clock);
        flush = 1'b0;
        enq_count = '0;
        #1;
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occupancy); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL flush_halted got %b want 0", halted); end
        n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", enq_ready); end
        mt_rd_ready = '1;
    endtask

    task automatic test_flush_dispatch();
        enq(4, mk(1, 2, 10, 1, 0, 0, 0, 1, RS_ALU, 0), mk(1, 2, 11, 1, 0, 0, 0, 1, RS_ALU, 1),
               mk(1, 2, 12, 1, 0, 0, 0, 1, RS_ALU, 2), mk(1, 2, 13, 1, 0, 0, 0, 1, RS_ALU, 3));
        n_checks++; if (disp_count !== 3'd4) begin n_fail++; $display("FAIL fd_pre got %0d want 4", disp_count); end
        flush = 1'b1;
        #1;
        n_checks++; if (disp_count !== 3'd0) begin n_fail++; $display("FAIL fd_count got %0d want 0", disp_count); end
        n_checks++; if (fl_alloc_count !== 3'd0) begin n_fail++; $display("FAIL fd_alloc got %0d want 0", fl_alloc_count); end
        n_checks++; if (mt_wr_valid !== 4'b0) begin n_fail++; $display("FAIL fd_mtwr got %b want 0000", mt_wr_valid); end
        @(negedge clock);
        flush = 1'b0;
        #1;
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL fd_occ got %0d want 0", occupancy); end
    endtask

    task automatic test_reset_mid();
        rob_credits = '0;
        enq(4, mk(1, 2, 3, 0, 0, 0, 0, 1, RS_ALU, 0), mk(1, 2, 3, 0, 0, 0, 0, 1, RS_ALU, 1),
               mk(1, 2, 3, 0, 0, 0, 0, 1, RS_ALU, 2), mk(1, 2, 3, 0, 0, 0, 0, 1, RS_ALU, 3));
        n_checks++; if (occupancy !== 5'd4) begin n_fail++; $display("FAIL rm_pre got %0d want 4", occupancy); end
        reset = 1'b0;
        enq_count = 3'd4;
        @(negedge clock);
        reset = 1'b1;
        enq_count = '0;
        rob_credits = 6'd8;
        #1;
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL rm_occ got %0d want 0", occupancy); end
        n_checks++; if (disp_count !== 3'd0) begin n_fail++; $display("FAIL rm_disp got %0d want 0", disp_count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_independent();
        test_forward();
        test_x0();
        test_mem_credit();
        test_branch_limit();
        test_full_wrap();
        test_halt_flush();
        test_flush_dispatch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
